// File: rtl/bus_rv32_fabric.sv
// RV32 core-bus fabric: base/mask decode onto peripheral channels with a wait/timeout handshake,
// plus a local IRQ pending/mask register pair aggregated into one core interrupt.
module bus_rv32_fabric #(
    parameter int unsigned                          ADDR_WIDTH = 32,
    parameter int unsigned                          DATA_WIDTH = 32,
    parameter int unsigned                          NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]     SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]     SLAVE_MASK = '0,
    parameter logic [ADDR_WIDTH-1:0]                LOCAL_BASE = ADDR_WIDTH'(32'hFFFF_FF00),
    parameter logic [ADDR_WIDTH-1:0]                LOCAL_MASK = ADDR_WIDTH'(32'hFFFF_FFF8),
    parameter int unsigned                          TIMEOUT    = 255
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr_i,
    input  logic                             cpu_we_i,
    input  logic                             cpu_re_i,
    input  logic [DATA_WIDTH-1:0]            cpu_data_i,
    output logic [DATA_WIDTH-1:0]            cpu_data_o,
    output logic                             cpu_ready_o,
    output logic                             cpu_err_o,
    output logic [NUM_SLAVES-1:0]            slv_sel_o,
    output logic [ADDR_WIDTH-1:0]            slv_addr_o,
    output logic                             slv_we_o,
    output logic [DATA_WIDTH-1:0]            slv_data_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_data_i,
    input  logic [NUM_SLAVES-1:0]            slv_ready_i,
    input  logic [NUM_SLAVES-1:0]            slv_irq_i,
    output logic                             irq_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [NUM_SLAVES-1:0]   pend_q, pend_d;
    logic [NUM_SLAVES-1:0]   mask_q, mask_d;
    logic [NUM_SLAVES-1:0]   irq_s1_q, irq_s1_d;
    logic [NUM_SLAVES-1:0]   irq_s2_q, irq_s2_d;
    logic                    irq_q, irq_d;

    logic                    local_hit;
    logic [NUM_SLAVES-1:0]   hit_oh;
    logic [NUM_SLAVES-1:0]   clr;
    logic [DATA_WIDTH-1:0]   local_rd;
    logic [DATA_WIDTH-1:0]   slv_rd;
    logic                    sel_ready;

    // Address decode; loop runs downward so the lowest matching index is the last written.
    always_comb begin
        hit_oh = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu_addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
        local_hit = (cpu_addr_i & LOCAL_MASK) == LOCAL_BASE;
        local_rd  = cpu_addr_i[2] ? DATA_WIDTH'(mask_q) : DATA_WIDTH'(pend_q);
        slv_rd    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) slv_rd = slv_rd | slv_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
        sel_ready = |(slv_ready_i & sel_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        mask_d   = mask_q;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (cpu_we_i || cpu_re_i) begin
                    addr_d  = cpu_addr_i;
                    we_d    = cpu_we_i;
                    wdata_d = cpu_data_i;
                    if (local_hit) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        rdata_d = cpu_we_i ? '0 : local_rd;
                        if (cpu_we_i) begin
                            if (cpu_addr_i[2]) mask_d = cpu_data_i[NUM_SLAVES-1:0];
                            else               clr    = cpu_data_i[NUM_SLAVES-1:0];
                        end
                    end else if (|hit_oh) begin
                        state_d = ACCESS;
                        sel_d   = hit_oh;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    sel_d   = '0;
                    rdata_d = slv_rd;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new edge beats a simultaneous write-1-to-clear.
        irq_s1_d = slv_irq_i;
        irq_s2_d = irq_s1_q;
        pend_d   = (pend_q & ~clr) | (irq_s1_q & ~irq_s2_q);
        irq_d    = |(pend_q & mask_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= '0;
            mask_q   <= '0;
            irq_s1_q <= '0;
            irq_s2_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            irq_s1_q <= irq_s1_d;
            irq_s2_q <= irq_s2_d;
            irq_q    <= irq_d;
        end
    end

    assign cpu_data_o  = rdata_q;
    assign cpu_ready_o = ready_q;
    assign cpu_err_o   = err_q;
    assign slv_sel_o   = sel_q;
    assign slv_addr_o  = addr_q;
    assign slv_we_o    = we_q;
    assign slv_data_o  = wdata_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_bus_rv32_fabric.sv
// Scoreboard bench for bus_rv32_fabric: stimulus pushes expected completions, a monitor pops them.
module tb_bus_rv32_fabric;

    localparam int unsigned NS      = 4;
    localparam int unsigned TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [31:0]   cpu_addr_i;
    logic          cpu_we_i, cpu_re_i;
    logic [31:0]   cpu_data_i;
    logic [31:0]   cpu_data_o;
    logic          cpu_ready_o, cpu_err_o;
    logic [NS-1:0] slv_sel_o;
    logic [31:0]   slv_addr_o;
    logic          slv_we_o;
    logic [31:0]   slv_data_o;
    logic [NS*32-1:0] slv_data_i;
    logic [NS-1:0] slv_ready_i;
    logic [NS-1:0] slv_irq_i;
    logic          irq_o;

    bus_rv32_fabric #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_SLAVES (NS),
        .SLAVE_BASE ({32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0100}),
        .SLAVE_MASK ({32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_FF00}),
        .LOCAL_BASE (32'hFFFF_FF00),
        .LOCAL_MASK (32'hFFFF_FFF8),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_re_i    (cpu_re_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_ready_o (cpu_ready_o),
        .cpu_err_o   (cpu_err_o),
        .slv_sel_o   (slv_sel_o),
        .slv_addr_o  (slv_addr_o),
        .slv_we_o    (slv_we_o),
        .slv_data_o  (slv_data_o),
        .slv_data_i  (slv_data_i),
        .slv_ready_i (slv_ready_i),
        .slv_irq_i   (slv_irq_i),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0]   base_m [NS] = '{32'h100, 32'h100, 32'h200, 32'h300};
    logic [31:0]   win_m  [NS] = '{32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_FF00};
    logic [NS-1:0] pend_m = '0;
    logic [NS-1:0] mask_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (cpu_err_o && !cpu_ready_o) chk("err_without_ready", 64'(cpu_err_o), 64'(0));
        if (cpu_ready_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 64'(cpu_ready_o), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("ready_cycle", 64'(cyc), 64'(e.cyc));
                chk("err", 64'(cpu_err_o), 64'(e.err));
                if (e.chk_data) chk("rdata", 64'(cpu_data_o), 64'(e.data));
                chk("sel_at_done", 64'(slv_sel_o), 64'(0));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missing_ready", 64'(0), 64'(1));
        end
    end

    // One CPU access; w = slave wait cycles before ready (w > TIMEOUT means the slave never answers).
    task automatic do_access(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                             input int w, input bit spur);
        exp_t          e;
        int            n;
        int            hit;
        bit            lhit;
        logic [NS-1:0] exp_sel;
        logic [31:0]   sdata;
        lhit = (addr & 32'hFFFF_FFF8) == 32'hFFFF_FF00;
        hit  = -1;
        if (!lhit) for (int i = NS - 1; i >= 0; i--) if ((addr & win_m[i]) == base_m[i]) hit = i;
        exp_sel = '0;
        if (hit >= 0) exp_sel[hit] = 1'b1;
        sdata = $urandom;
        @(posedge clk); #1;
        n = cyc;
        cpu_addr_i = addr; cpu_we_i = we; cpu_re_i = !we; cpu_data_i = wdata;
        e.err = 1'b0; e.data = '0; e.chk_data = 1'b1;
        if (lhit) begin
            e.cyc = n + 1;
            e.chk_data = !we;
            e.data = addr[2] ? {28'b0, mask_m} : {28'b0, pend_m};
            if (we) begin
                if (addr[2]) mask_m = wdata[NS-1:0];
                else         pend_m = pend_m & ~wdata[NS-1:0];
            end
        end else if (hit < 0) begin
            e.cyc = n + 1; e.err = 1'b1;
        end else if (w > int'(TIMEOUT)) begin
            e.cyc = n + 2 + int'(TIMEOUT); e.err = 1'b1;
        end else begin
            e.cyc = n + 2 + w; e.data = sdata;
        end
        exp_q.push_back(e);
        for (int c = n + 1; c <= e.cyc; c++) begin
            @(posedge clk); #1;
            cpu_we_i = 1'b0;
            cpu_re_i = spur && (c == n + 1);
            if (spur) cpu_addr_i = 32'h8000_0000;
            slv_ready_i = NS'($urandom) & ~exp_sel;
            slv_data_i  = {$urandom, $urandom, $urandom, $urandom};
            if (hit >= 0 && w <= int'(TIMEOUT) && c == n + 1 + w) begin
                slv_ready_i[hit] = 1'b1;
                slv_data_i[hit*32 +: 32] = sdata;
            end
            if (c == n + 1) begin
                @(negedge clk);
                chk("sel_onehot", 64'(slv_sel_o), 64'(exp_sel));
                if (hit >= 0) begin
                    chk("slv_addr", 64'(slv_addr_o), 64'(addr));
                    chk("slv_we", 64'(slv_we_o), 64'(we));
                    chk("slv_wdata", 64'(slv_data_o), 64'(wdata));
                end
            end
        end
        @(posedge clk); #1;
        cpu_re_i = 1'b0;
        slv_ready_i = '0;
    endtask

    initial begin
        int p;
        reset_i = 1'b1; cpu_addr_i = '0; cpu_we_i = 1'b0; cpu_re_i = 1'b0; cpu_data_i = '0;
        slv_data_i = '0; slv_ready_i = '0; slv_irq_i = '0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(cpu_ready_o), 64'(0));
        chk("rst_err", 64'(cpu_err_o), 64'(0));
        chk("rst_data", 64'(cpu_data_o), 64'(0));
        chk("rst_sel", 64'(slv_sel_o), 64'(0));
        chk("rst_addr", 64'(slv_addr_o), 64'(0));
        chk("rst_we", 64'(slv_we_o), 64'(0));
        chk("rst_wdata", 64'(slv_data_o), 64'(0));
        chk("rst_irq", 64'(irq_o), 64'(0));

        // Slave 2 read with three wait cycles, then a fixed data word.
        begin
            exp_t e;
            int   n;
            @(posedge clk); #1;
            n = cyc; cpu_addr_i = 32'h204; cpu_re_i = 1'b1;
            e.cyc = n + 5; e.data = 32'hCAFE_0001; e.err = 1'b0; e.chk_data = 1'b1;
            exp_q.push_back(e);
            @(posedge clk); #1 cpu_re_i = 1'b0;
            @(negedge clk) chk("s2_sel", 64'(slv_sel_o), 64'(4'b0100));
            repeat (3) @(posedge clk);
            #1 slv_ready_i = 4'b0100; slv_data_i[64 +: 32] = 32'hCAFE_0001;
            @(posedge clk); #1 slv_ready_i = '0;
            @(posedge clk); #1;
        end

        do_access(32'h100, 1'b0, 32'h0, 1, 1'b0);             // overlap -> slave 0
        do_access(32'h8000_0000, 1'b0, 32'h0, 0, 1'b0);       // unmapped
        do_access(32'h304, 1'b0, 32'h0, 99, 1'b0);            // timeout
        do_access(32'h110, 1'b1, 32'h1234_5678, 3, 1'b1);     // strobe during ACCESS ignored
        do_access(32'hFFFF_FF04, 1'b1, 32'h3, 0, 1'b0);       // IRQ_MASK = 3

        // Single-cycle IRQ pulse on bit 1.
        @(posedge clk); #1 slv_irq_i[1] = 1'b1; p = cyc;
        @(posedge clk); #1 slv_irq_i[1] = 1'b0;
        @(posedge clk);
        @(negedge clk) chk("irq_n2", 64'(irq_o), 64'(0));
        @(posedge clk);
        @(negedge clk) chk("irq_n3", 64'(irq_o), 64'(1));
        chk("irq_cycle", 64'(cyc - p), 64'(3));
        pend_m[1] = 1'b1;
        do_access(32'hFFFF_FF00, 1'b0, 32'h0, 0, 1'b0);

        // W1C of bit 1 coinciding with a fresh edge on bit 1: the edge wins.
        @(posedge clk); #1 slv_irq_i[1] = 1'b1;
        do_access(32'hFFFF_FF00, 1'b1, 32'h2, 0, 1'b0);
        pend_m[1] = 1'b1;
        do_access(32'hFFFF_FF00, 1'b0, 32'h0, 0, 1'b0);
        do_access(32'hFFFF_FF00, 1'b1, 32'h2, 0, 1'b0);       // plain clear, level still high
        do_access(32'hFFFF_FF00, 1'b0, 32'h0, 0, 1'b0);
        slv_irq_i[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) chk("irq_cleared", 64'(irq_o), 64'(0));

        // Randomized mix of slave, local and unmapped accesses.
        for (int k = 0; k < 40; k++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 5);
            if (kind < 4)       a = base_m[kind] | ($urandom & ~win_m[kind]);
            else if (kind == 4) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 7));
            else                a = 32'h8000_0000 | 32'($urandom_range(0, 255));
            do_access(a, 1'($urandom), $urandom, $urandom_range(0, 6), 1'($urandom));
        end
        repeat (2) @(posedge clk);
        @(negedge clk) chk("irq_random", 64'(irq_o), 64'(|(pend_m & mask_m)));

        // Reset in the middle of a slave access; pending/mask made non-zero beforehand.
        do_access(32'hFFFF_FF04, 1'b1, 32'hA, 0, 1'b0);
        @(posedge clk); #1 slv_irq_i[3] = 1'b1;
        @(posedge clk); #1 slv_irq_i[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1 cpu_re_i = 1'b1; cpu_addr_i = 32'h300;
        @(posedge clk); #1 cpu_re_i = 1'b0;
        @(negedge clk) chk("pre_rst_sel", 64'(slv_sel_o), 64'(4'b1000));
        @(posedge clk); #1 reset_i = 1'b1;
        @(posedge clk); #1 reset_i = 1'b0;
        @(negedge clk);
        chk("midrst_sel", 64'(slv_sel_o), 64'(0));
        chk("midrst_ready", 64'(cpu_ready_o), 64'(0));
        mask_m = '0; pend_m = '0;
        repeat (8) @(posedge clk);
        do_access(32'hFFFF_FF04, 1'b0, 32'h0, 0, 1'b0);
        do_access(32'hFFFF_FF00, 1'b0, 32'h0, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rv32_fabric.md
# bus_rv32_fabric

Parametrised bus fabric between the RV32 core bus and up to NUM_SLAVES peripheral channels. It decodes each CPU access against per-slave base/mask windows and runs a request/ready handshake with a per-access timeout. Completion is returned to the core as a ready or error pulse. Slave interrupt lines are aggregated into one core interrupt through local pending/mask registers. It sits between the core and the peripheral register blocks, and gives the fixed-bus interface wait-state, error and interrupt-masking behaviour.

## Interface
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width.
- NUM_SLAVES, 4, slave channel count (1..16).
- SLAVE_BASE, all zeros, packed NUM_SLAVES*ADDR_WIDTH; slave i base in slice i.
- SLAVE_MASK, all zeros, packed NUM_SLAVES*ADDR_WIDTH; slave i decode mask.
- LOCAL_BASE, 'hFFFF_FF00, base of the local IRQ register window.
- LOCAL_MASK, 'hFFFF_FFF8, decode mask of the local window.
- TIMEOUT, 255, maximum wait cycles before an error response; 0 disables the timeout.
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- cpu_addr_i  in  ADDR_WIDTH  access address.
- cpu_we_i  in  1  single-cycle write strobe.
- cpu_re_i  in  1  single-cycle read strobe.
- cpu_data_i  in  DATA_WIDTH  write data, valid with the strobe.
- cpu_data_o  out  DATA_WIDTH  read data, valid while cpu_ready_o is high.
- cpu_ready_o  out  1  one-cycle completion pulse.
- cpu_err_o  out  1  one-cycle error flag, coincident with cpu_ready_o.
- slv_sel_o  out  NUM_SLAVES  one-hot select, held until the access ends.
- slv_addr_o  out  ADDR_WIDTH  latched address.
- slv_we_o  out  1  latched write flag.
- slv_data_o  out  DATA_WIDTH  latched write data.
- slv_data_i  in  NUM_SLAVES*DATA_WIDTH  per-slave read data.
- slv_ready_i  in  NUM_SLAVES  per-slave completion.
- slv_irq_i  in  NUM_SLAVES  level interrupts from the slaves.
- irq_o  out  1  aggregated interrupt to the core.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:** a strobe (cpu_re_i | cpu_we_i) is accepted.
  - The accept latches address, data and we; cpu_we_i has priority if both strobes are high.
- **Decode** of an accepted access:
  - Local window hit, checked first: (addr & LOCAL_MASK) == LOCAL_BASE.
  - Otherwise slave i hits when (addr & SLAVE_MASK[i]) == SLAVE_BASE[i]; the lowest index wins.
  - No hit is unmapped.
- **Slave hit:** go to ACCESS.
  - slv_sel_o[i] is asserted; the timeout counter is cleared.
- **Local hit or unmapped:** go straight to DONE.
  - A local write updates its register at the same time.
  - Unmapped sets err; read data is 0.
- **ACCESS:**
  - When slv_ready_i[i] of the selected slave is high, capture slv_data_i slice i and go to DONE.
  - slv_ready_i of non-selected slaves is ignored.
  - Each cycle without ready increments the counter. When the counter reaches TIMEOUT (TIMEOUT != 0), go to DONE with err and data 0.
- **DONE:** cpu_ready_o = 1 for one cycle, cpu_err_o set per the outcome; then back to IDLE.
- Strobes arriving in ACCESS or DONE are ignored; the core issues the next access only after cpu_ready_o.
- **Local registers,** selected by addr[2]:
  - 0 = IRQ_PENDING: read; write-1-to-clear.
  - 1 = IRQ_MASK: read/write.
  - Both are NUM_SLAVES wide and zero-extended on read.
- **Pending:** bit i sets on a rising edge of slv_irq_i[i], using a registered copy of the input.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq_o = |(IRQ_PENDING & IRQ_MASK), registered.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - cpu_data_o, cpu_ready_o, cpu_err_o, slv_sel_o, slv_addr_o, slv_we_o, slv_data_o = 0.
  - IRQ_PENDING, IRQ_MASK, irq_o and the IRQ edge registers = 0.
- **Slave access:** strobe in cycle N.
  - slv_sel_o is high from N+1.
  - If ready arrives in cycle M (M ≥ N+1), cpu_ready_o is high in M+1 and slv_sel_o drops in M+1.
  - Minimum latency is 2 cycles.
- **Local/unmapped access:** cpu_ready_o in N+1.
- **Timeout:** with no ready, err is reported in cycle N+1+TIMEOUT+1.
- **IRQ:** slv_irq_i rising in cycle N sets pending in N+2; irq_o is high in N+3 if the bit is unmasked.
- **Reset mid-access:** slv_sel_o drops the next cycle and no ready or err pulse is produced.

## Test plan
- Read of slave 2 (base 'h200, mask 'hFFFF_FF00, addr 'h204); ready after 3 wait cycles with data 'hCAFE_0001 -> cpu_data_o = 'hCAFE_0001, ready 5 cycles after the strobe, err = 0.
- Overlapping windows: slaves 0 and 1 both match 'h100 -> only slv_sel_o[0] is asserted.
- Read of unmapped 'h8000_0000 -> ready and err at N+1, data 0. With TIMEOUT = 4 and a slave that never responds -> err at N+6.
- Write 'h3 to IRQ_MASK, pulse slv_irq_i[1] -> irq_o high in 3 cycles. W1C 'h2 in the same cycle as a new edge on bit 1 -> pending bit stays 1.
- Assert reset_i during ACCESS -> slv_sel_o = 0 the next cycle, no cpu_ready_o, and the registers read 0.
- Strobe issued during ACCESS -> ignored; exactly one cpu_ready_o pulse for the first access.
